// File: rtl/rv_core_pkg.sv
// Shared core definitions: datapath width, control-unit opcode constants,
// the canonical NOP and the fetch FSM state encoding.
package rv_core_pkg;

  localparam int XLEN = 32;

  // Major opcodes decoded by the control unit (instr[6:0])
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

  // addi x0,x0,0 -- presented to decode whenever nothing valid is held
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch FSM: issue request, wait for response, hold for decode
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Saturating 32-bit increment used by the event counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave). One request outstanding at a time.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit_pc_gen.sv
// Next-PC selection for the fetch unit: redirect target (forced to word
// alignment) beats sequential pc+4, otherwise the PC holds. Also flags a
// redirect target whose low two bits are non-zero.
module ifu_pc_gen #(
  parameter int XLEN = rv_core_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_next,
  output logic            misalign
);

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target;

  // Pick the next PC; pc+4 wraps naturally modulo 2^XLEN
  always_comb begin
    pc_inc   = pc + XLEN'(3'd4);
    target   = {redirect_pc[XLEN-1:2], 2'b00};
    misalign = redirect && (redirect_pc[1:0] != 2'b00);
    if (redirect) begin
      pc_next = target;
    end else if (advance) begin
      pc_next = pc_inc;
    end else begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage feeding decode/control. Issues one word request at a time to
// instruction memory, holds the returned instruction for decode, and handles
// branch redirects by squashing any in-flight (stale) response.
// Optional build macro: IFU_PERF_CNT_EN adds saturating fetch/stall/flush
// event counters as extra outputs; behaviour is otherwise identical.
module instr_fetch_unit #(
  parameter int                       XLEN      = rv_core_pkg::XLEN,
  parameter logic [XLEN-1:0]          RESET_PC  = XLEN'(32'h0000_0000),
  parameter logic [31:0]              NOP_INSTR = rv_core_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.master   imem,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr_out,
  output logic [6:0]           opcode,
  output logic [XLEN-1:0]      instr_pc,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 misalign_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  import rv_core_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            req_q, req_d;
  logic            kill_q, kill_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic            accept;
  logic            advance;
  logic            flush_evt;

  ifu_pc_gen #(
    .XLEN (XLEN)
  ) u_pc_gen (
    .pc          (pc_q),
    .advance     (advance),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_next     (pc_d),
    .misalign    (mis_d)
  );

  // Fetch FSM next-state; redirect outranks every other event in a cycle
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    advance    = 1'b0;
    flush_evt  = 1'b0;
    // req_q is only ever high while in ST_FETCH (it is low for the first
    // cycle after reset, so nothing can be accepted before it is driven)
    accept     = req_q && imem.imem_ready;

    case (state_q)
      ST_FETCH: begin
        if (accept) begin
          state_d = ST_WAIT;
          // a request accepted alongside a redirect fetches the old path
          kill_d  = redirect;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          if (imem.imem_rvalid) begin
            state_d   = ST_FETCH;
            kill_d    = 1'b0;
            flush_evt = 1'b1;
          end else begin
            kill_d    = 1'b1;
          end
        end else if (imem.imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q) begin
            state_d   = ST_FETCH;
            flush_evt = 1'b1;
          end else begin
            state_d    = ST_HOLD;
            valid_d    = 1'b1;
            instr_d    = imem.imem_rdata;
            instr_pc_d = pc_q;
            advance    = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d   = ST_FETCH;
          valid_d   = 1'b0;
          instr_d   = NOP_INSTR;
          flush_evt = 1'b1;
        end else if (instr_ready) begin
          state_d = ST_FETCH;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_FETCH;
        kill_d  = 1'b0;
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    endcase

    req_d = (state_d == ST_FETCH);
  end

  // FSM, PC and decode-facing output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      kill_q     <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      mis_q      <= mis_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign instr_out      = instr_q;
  assign opcode         = instr_q[6:0];
  assign instr_pc       = instr_pc_q;
  assign misalign_err   = mis_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event counters; a held instruction dropped by redirect is a flush, not a fetch
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid_q && instr_ready && !redirect) begin
      fetch_cnt_d = sat_inc32(fetch_cnt_q);
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (valid_q && !instr_ready) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_evt) begin
      flush_cnt_d = sat_inc32(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  // flush_evt only feeds the optional counters
  logic unused_flush;
  assign unused_flush = flush_evt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with
// constant expectations, then randomized traffic checked every cycle
// against a transaction-flag reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [6:0]  opcode;
  logic [31:0] instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        misalign_err;

  int vectors = 0;
  int errors  = 0;
  bit auto_rsp = 1'b0;

  instr_fetch_unit_if #(.XLEN(32)) imem ();

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_out    (instr_out),
    .opcode       (opcode),
    .instr_pc     (instr_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_busy: a request was accepted, response pending
  // m_stale: that pending response belongs to an abandoned path
  // m_have: an instruction is being offered to decode
  // m_first: the idle cycle right after reset
  bit          m_first, m_busy, m_stale, m_have, m_mis;
  logic [31:0] m_pc, m_ipc, m_ins;
  logic [31:0] m_tgt;
  logic        m_req;
  assign m_tgt = {redirect_pc[31:2], 2'b00};
  assign m_req = !m_first && !m_busy && !m_have;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_first <= 1'b1; m_busy <= 1'b0; m_stale <= 1'b0; m_have <= 1'b0;
      m_mis <= 1'b0; m_pc <= RPC; m_ipc <= RPC; m_ins <= NOP;
    end else begin
      m_first <= 1'b0;
      m_mis   <= redirect && (redirect_pc[1:0] != 2'b00);
      if (m_have) begin
        if (redirect || instr_ready) begin
          m_have <= 1'b0;
          m_ins  <= NOP;
        end
        if (redirect) m_pc <= m_tgt;
      end else if (m_busy) begin
        if (redirect) begin
          m_pc <= m_tgt;
          if (imem.imem_rvalid) begin m_busy <= 1'b0; m_stale <= 1'b0; end
          else m_stale <= 1'b1;
        end else if (imem.imem_rvalid) begin
          m_busy  <= 1'b0;
          m_stale <= 1'b0;
          if (!m_stale) begin
            m_have <= 1'b1; m_ins <= imem.imem_rdata; m_ipc <= m_pc; m_pc <= m_pc + 32'd4;
          end
        end
      end else begin
        if (m_req && imem.imem_ready) begin m_busy <= 1'b1; m_stale <= redirect; end
        if (redirect) m_pc <= m_tgt;
      end
    end
  end

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    logic acc;
    acc = imem.imem_req && imem.imem_ready;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      imem.imem_rvalid = acc;
      imem.imem_rdata  = $urandom;
    end
  endtask

  task automatic test_reset();
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem.imem_req); end
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    vectors++; if (instr_out !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", instr_out, NOP); end
    vectors++; if (opcode !== 7'b0010011) begin errors++; $display("FAIL rst_opcode: got %b want 0010011", opcode); end
    vectors++; if (instr_pc !== RPC) begin errors++; $display("FAIL rst_pc: got %h want %h", instr_pc, RPC); end
    vectors++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b want 0", misalign_err); end
    rst_n = 1'b1;
    tick();
    vectors++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %b want 1", imem.imem_req); end
    vectors++; if (imem.imem_addr !== RPC) begin errors++; $display("FAIL rst_first_addr: got %h want %h", imem.imem_addr, RPC); end
  endtask

  task automatic test_stream();
    logic [31:0] addrs [$];
    logic [31:0] exp_ins;
    int nvalid;
    nvalid = 0; exp_ins = NOP;
    imem.imem_ready = 1'b1; instr_ready = 1'b1; auto_rsp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (imem.imem_req) addrs.push_back(imem.imem_addr);
      if (instr_valid) begin
        nvalid++;
        vectors++; if (instr_out !== exp_ins) begin errors++; $display("FAIL stream_instr: got %h want %h", instr_out, exp_ins); end
        vectors++; if (opcode !== exp_ins[6:0]) begin errors++; $display("FAIL stream_opcode: got %b want %b", opcode, exp_ins[6:0]); end
      end
      tick();
      if (imem.imem_rvalid) exp_ins = imem.imem_rdata;
    end
    vectors++; if (addrs.size() !== 2) begin errors++; $display("FAIL stream_nreq: got %0d want 2", addrs.size()); end
    else begin
      vectors++; if (addrs[0] !== 32'h0) begin errors++; $display("FAIL stream_addr0: got %h want 0", addrs[0]); end
      vectors++; if (addrs[1] !== 32'h4) begin errors++; $display("FAIL stream_addr1: got %h want 4", addrs[1]); end
    end
    vectors++; if (nvalid !== 2) begin errors++; $display("FAIL stream_rate: got %0d valid want 2 in 6 cycles", nvalid); end
    imem.imem_ready = 1'b0;
  endtask

  task automatic test_ready_stall();
    for (int i = 0; i < 4; i++) begin
      vectors++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL stall_req c%0d: got %b want 1", i, imem.imem_req); end
      vectors++; if (imem.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr c%0d: got %h want 8", i, imem.imem_addr); end
      vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_valid c%0d: got %b want 0", i, instr_valid); end
      tick();
    end
    vectors++; if (imem.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr_end: got %h want 8", imem.imem_addr); end
  endtask

  task automatic test_decode_stall();
    auto_rsp = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_ready = 1'b1; instr_ready = 1'b0;
    tick();
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h00A0_0093;
    tick();
    imem.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL dstall_valid c%0d: got %b want 1", i, instr_valid); end
      vectors++; if (instr_out !== 32'h00A0_0093) begin errors++; $display("FAIL dstall_instr c%0d: got %h want 00a00093", i, instr_out); end
      vectors++; if (instr_pc !== 32'h8) begin errors++; $display("FAIL dstall_pc c%0d: got %h want 8", i, instr_pc); end
      vectors++; if (opcode !== 7'b0010011) begin errors++; $display("FAIL dstall_opcode c%0d: got %b want 0010011", i, opcode); end
      vectors++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL dstall_req c%0d: got %b want 0", i, imem.imem_req); end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL dstall_clear: got %b want 0", instr_valid); end
    vectors++; if (instr_out !== NOP) begin errors++; $display("FAIL dstall_nop: got %h want %h", instr_out, NOP); end
    vectors++; if (imem.imem_addr !== 32'hC || imem.imem_req !== 1'b1) begin errors++; $display("FAIL dstall_next: got req %b addr %h want 1 c", imem.imem_req, imem.imem_addr); end
  endtask

  task automatic test_redirect_wait();
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    vectors++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rw_mis: got %b want 0", misalign_err); end
    vectors++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rw_req_wait: got %b want 0", imem.imem_req); end
    imem.imem_rvalid = 1'b1; imem.imem_rdata = $urandom;
    tick();
    imem.imem_rvalid = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_discard: got %b want 0", instr_valid); end
    vectors++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h100) begin errors++; $display("FAIL rw_refetch: got req %b addr %h want 1 100", imem.imem_req, imem.imem_addr); end
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h0020_81B3;
    tick();
    imem.imem_rvalid = 1'b0;
    vectors++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rw_valid: got %b want 1", instr_valid); end
    vectors++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL rw_pc: got %h want 100", instr_pc); end
    vectors++; if (opcode !== 7'b0110011) begin errors++; $display("FAIL rw_opcode: got %b want 0110011", opcode); end
  endtask

  task automatic test_redirect_hold_misalign();
    redirect = 1'b1; redirect_pc = 32'h102; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rh_drop: got %b want 0", instr_valid); end
    vectors++; if (instr_out !== NOP) begin errors++; $display("FAIL rh_nop: got %h want %h", instr_out, NOP); end
    vectors++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL rh_mis_pulse: got %b want 1", misalign_err); end
    vectors++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h100) begin errors++; $display("FAIL rh_addr: got req %b addr %h want 1 100", imem.imem_req, imem.imem_addr); end
    tick();
    vectors++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rh_mis_once: got %b want 0", misalign_err); end
    vectors++; if (imem.imem_addr !== 32'h100) begin errors++; $display("FAIL rh_addr_hold: got %h want 100", imem.imem_addr); end
  endtask

  task automatic test_reset_midway();
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL mr_req: got %b want 0", imem.imem_req); end
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b want 0", instr_valid); end
    vectors++; if (instr_pc !== RPC) begin errors++; $display("FAIL mr_pc: got %h want %h", instr_pc, RPC); end
    vectors++; if (instr_out !== NOP) begin errors++; $display("FAIL mr_instr: got %h want %h", instr_out, NOP); end
    imem.imem_rvalid = 1'b1; imem.imem_rdata = $urandom;
    tick();
    rst_n = 1'b1;
    tick();
    imem.imem_rvalid = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mr_ignore: got %b want 0", instr_valid); end
    vectors++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== RPC) begin errors++; $display("FAIL mr_restart: got req %b addr %h want 1 %h", imem.imem_req, imem.imem_addr, RPC); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      imem.imem_ready  = $urandom_range(0, 1);
      imem.imem_rvalid = ($urandom_range(0, 2) == 0);
      imem.imem_rdata  = $urandom;
      instr_ready      = $urandom_range(0, 1);
      redirect         = ($urandom_range(0, 7) == 0);
      redirect_pc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick();
      vectors++; if (imem.imem_req !== m_req) begin errors++; $display("FAIL rnd_req c%0d: got %b want %b", i, imem.imem_req, m_req); end
      vectors++; if (imem.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", i, imem.imem_addr, m_pc); end
      vectors++; if (instr_valid !== m_have) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", i, instr_valid, m_have); end
      vectors++; if (instr_out !== m_ins) begin errors++; $display("FAIL rnd_instr c%0d: got %h want %h", i, instr_out, m_ins); end
      vectors++; if (opcode !== m_ins[6:0]) begin errors++; $display("FAIL rnd_opcode c%0d: got %b want %b", i, opcode, m_ins[6:0]); end
      vectors++; if (instr_pc !== m_ipc) begin errors++; $display("FAIL rnd_ipc c%0d: got %h want %h", i, instr_pc, m_ipc); end
      vectors++; if (misalign_err !== m_mis) begin errors++; $display("FAIL rnd_mis c%0d: got %b want %b", i, misalign_err, m_mis); end
    end
    redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ready_stall();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_hold_misalign();
    test_reset_midway();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
